output_uart_port: RTL and testbench
===================================

# output_uart_port

Downstream output stage for the Karpentium processor. Captures 16-bit result words strobed off the processor output register into a small FIFO, then serialises each word as two 8N1 UART bytes, high byte first, on a single `tx` line. Decouples processor execution rate from the slow serial link and flags words lost to overflow.

## Interface
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; ≥2

- `clk`  in  1  system clock, all state updates on rising edge
- `clr`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe: push `wr_data` this cycle
- `wr_data`  in  16  word from processor output register
- `full`  out  1  FIFO holds `DEPTH` words
- `empty`  out  1  FIFO holds 0 words
- `busy`  out  1  transmitter not in IDLE
- `overflow`  out  1  sticky: a write was dropped while full
- `tx`  out  1  UART serial output, idle high

## Operation
- Reset (`clr` low, asynchronous): FIFO pointers and count cleared; `empty`=1, `full`=0, `busy`=0, `overflow`=0, `tx`=1, FSM in IDLE, bit and baud counters 0. Reset mid-frame aborts the frame; `tx` goes high immediately, with no completion.
- Write: `wr_en`=1 and `full`=0 pushes `wr_data` at the edge. `wr_en`=1 with `full`=1 drops the word and sets `overflow`; `full` is sampled before the edge, so a pop in the same cycle does not rescue the write.
- Simultaneous push and pop: both occur and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP; a `byte_sel` register selects the high byte (0) or low byte (1).
  - IDLE and `empty`=0: pop the word into a 16-bit shift holder, `byte_sel`=0, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits of the selected byte, LSB first, each `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
    - If `byte_sel`=0: set `byte_sel`=1 and go to START.
    - If `byte_sel`=1 and `empty`=0: pop the next word and go to START at the same edge, with no idle gap.
    - Otherwise go to IDLE.
- `tx` is registered. `busy` = state ≠ IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps. Bit counter counts 0..7. Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits.

## Timing
- Write at edge N: `empty` falls after N. The FSM pops at edge N+1, and `tx` falls after N+1.
- One word = 20·`CLKS_PER_BIT` cycles of line time.
- Back-to-back words are contiguous: stop bit of word k is followed directly by the start bit of word k+1.
- `full` and `empty` update on the same edge as the push or pop that changes them.
- `overflow` is set at the edge of the dropped write and is cleared only by `clr`.

## Structure
- Shared package `karpentium_io_pkg`:
  - FSM state typedef (IDLE/START/DATA/STOP)
  - `START_BIT`=0, `STOP_BIT`=1, `BITS_PER_BYTE`=8, `BYTES_PER_WORD`=2
- Sub-module `sync_word_fifo` holds storage, pointers, count, `full`/`empty` and overflow detection.
- The top level holds the UART FSM, baud counter, bit counter and shift holder.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `DEPTH`=4.
- Single write of 16'hA55A into an idle block:
  - `tx` shows start, bits 1,0,1,0,0,1,0,1, stop (0xA5), then start, 0,1,0,1,1,0,1,0, stop (0x5A).
  - 80 cycles total, then `busy`=0 and `empty`=1.
- Six writes on consecutive edges:
  - Word 1 is popped on the edge after it is written.
  - `full`=1 after the fifth write; the sixth write is dropped and `overflow`=1.
  - Exactly 5 words are transmitted, in order.
- Two writes 1 cycle apart (16'h0001, 16'hFFFF): 160 contiguous line cycles, with no idle-high gap between the first word's low-byte stop bit and the second word's start bit.
- Assert `clr` low mid-DATA of the high byte with 2 words queued:
  - `tx`=1, `empty`=1, `busy`=0 immediately, without waiting for an edge.
  - After release, no further frames.
- Push and pop in the same cycle at count=1: count stays 1, `empty`=0, and the data order is preserved.

Source files
------------

// File: rtl/karpentium_io_pkg.sv
// Shared definitions for the Karpentium output UART port: FSM state type,
// UART framing levels and word/byte geometry.
package karpentium_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_BYTE  = 8;
  localparam int   BYTES_PER_WORD = 2;

  // High byte goes out first (byte_sel=0), then the low byte (byte_sel=1).
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic byte_sel);
    return byte_sel ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with first-word-fall-through read data, occupancy
// flags and a sticky flag for writes dropped while full.
module sync_word_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  // Full is judged on the pre-edge count, so a same-cycle pop never admits a write.
  assign push     = wr_en && !full;
  assign pop      = rd_en && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_data  = mem[rd_ptr];

  // Word storage; data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky overflow; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/output_uart_port.sv
// Output stage: buffers 16-bit result words and sends each as two 8N1 UART
// bytes (high byte first) on a registered tx line, back to back with no idle gap.
module output_uart_port
  import karpentium_io_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(BITS_PER_BYTE - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic              byte_sel;
  logic [15:0]       hold;
  logic [15:0]       fifo_data;
  logic [7:0]        cur_byte;
  logic              baud_last;
  logic              pop;

  sync_word_fifo #(
    .DATA_W (16),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign cur_byte  = select_byte(hold, byte_sel);
  assign busy      = (state != ST_IDLE);

  // A word leaves the FIFO either from IDLE or at the very end of a low-byte
  // stop bit, which is what makes consecutive words contiguous on the line.
  assign pop = !empty && ((state == ST_IDLE) ||
                          (state == ST_STOP && baud_last && byte_sel));

  // Capture the popped word; it is read byte by byte during the two frames.
  always_ff @(posedge clk) begin
    if (pop) hold <= fifo_data;
  end

  // UART framing FSM; tx is loaded with the level of the cell being entered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_sel <= 1'b0;
      tx       <= STOP_BIT;
    end else begin
      if (state == ST_IDLE) baud_cnt <= '0;
      else                  baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state    <= ST_START;
            byte_sel <= 1'b0;
            tx       <= START_BIT;
          end
        end
        ST_START: begin
          if (baud_last) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= cur_byte[0];
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            if (bit_cnt == BIT_LAST) begin
              state <= ST_STOP;
              tx    <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= ST_START;
              tx       <= START_BIT;
            end else if (pop) begin
              byte_sel <= 1'b0;
              state    <= ST_START;
              tx       <= START_BIT;
            end else begin
              state <= ST_IDLE;
              tx    <= STOP_BIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_uart_port.sv
// Bench for output_uart_port: a line-level UART receiver decodes tx into bytes
// with their start times; expectations come from a word-level timing model.
module tb_output_uart_port;

  localparam int C        = 4;
  localparam int DEPTH    = 4;
  localparam int HALF     = C / 2;
  localparam int WORD_CYC = 20 * C;

  logic        clk;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;
  logic        tx;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;

  output_uart_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples tx mid-cell on falling clock edges.
  logic [7:0] rx_b[$];
  int         rx_t[$];
  int         frame_err  = 0;
  int         mon_starts = 0;
  bit         mon_on     = 0;
  int         mon_cnt    = 0;
  int         mon_t      = 0;
  logic [7:0] rx_sh      = '0;

  always @(negedge clk) begin
    if (!clr) begin
      mon_on = 0;
    end else if (!mon_on) begin
      if (tx == 1'b0) begin
        mon_on = 1; mon_cnt = 0; mon_t = cyc; mon_starts++;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == HALF) begin
        if (mon_cnt / C == 0) begin
          if (tx !== 1'b0) frame_err++;
        end else if (mon_cnt / C <= 8) begin
          rx_sh = {tx, rx_sh[7:1]};
        end else begin
          if (tx !== 1'b1) frame_err++;
          rx_b.push_back(rx_sh);
          rx_t.push_back(mon_t);
          mon_on = 0;
        end
      end
    end
  end

  task automatic clear_mon();
    rx_b.delete(); rx_t.delete(); frame_err = 0; mon_starts = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
  endtask

  // Drive one write; returns the number of the edge that samples it.
  task automatic push(input logic [15:0] d, output int edge_n);
    @(negedge clk); wr_en = 1'b1; wr_data = d; edge_n = cyc + 1;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    nchecks++; if (empty !== 1'b1)    begin nerr++; $display("FAIL rst_empty: got %b want 1", empty); end
    nchecks++; if (full !== 1'b0)     begin nerr++; $display("FAIL rst_full: got %b want 0", full); end
    nchecks++; if (busy !== 1'b0)     begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    nchecks++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    nchecks++; if (tx !== 1'b1)       begin nerr++; $display("FAIL rst_tx: got %b want 1", tx); end
    clr = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    nchecks++; if (busy !== 1'b0 || tx !== 1'b1 || mon_starts != 0)
      begin nerr++; $display("FAIL rst_quiet: busy=%b tx=%b starts=%0d want 0/1/0", busy, tx, mon_starts); end
  endtask

  task automatic test_single();
    int n;
    do_reset(); clear_mon();
    push(16'hA55A, n);
    nchecks++; if (empty !== 1'b0 || busy !== 1'b0)
      begin nerr++; $display("FAIL single_after_write: empty=%b busy=%b want 0/0", empty, busy); end
    @(posedge clk); #1;
    nchecks++; if (empty !== 1'b1 || busy !== 1'b1 || tx !== 1'b0)
      begin nerr++; $display("FAIL single_pop: empty=%b busy=%b tx=%b want 1/1/0", empty, busy, tx); end
    repeat (79) @(posedge clk); #1;
    nchecks++; if (busy !== 1'b1 || tx !== 1'b1)
      begin nerr++; $display("FAIL single_last_cycle: busy=%b tx=%b want 1/1", busy, tx); end
    @(posedge clk); #1;
    nchecks++; if (busy !== 1'b0 || empty !== 1'b1 || tx !== 1'b1)
      begin nerr++; $display("FAIL single_done: busy=%b empty=%b tx=%b want 0/1/1", busy, empty, tx); end
    repeat (10) @(posedge clk); #1;
    nchecks++; if (rx_b.size() != 2 || frame_err != 0)
      begin nerr++; $display("FAIL single_bytes: got %0d bytes err=%0d want 2/0", rx_b.size(), frame_err); end
    else begin
      nchecks++; if (rx_b[0] !== 8'hA5 || rx_b[1] !== 8'h5A)
        begin nerr++; $display("FAIL single_data: got %h %h want a5 5a", rx_b[0], rx_b[1]); end
      nchecks++; if (rx_t[0] != n + 1 || rx_t[1] != n + 1 + 10 * C)
        begin nerr++; $display("FAIL single_timing: got %0d %0d want %0d %0d", rx_t[0], rx_t[1], n + 1, n + 1 + 10 * C); end
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    logic [7:0] exp_b[4];
    exp_b = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    do_reset(); clear_mon();
    push(16'h0001, n0);
    @(posedge clk); #1;
    push(16'hFFFF, n1);
    repeat (2 * WORD_CYC + 20) @(posedge clk); #1;
    nchecks++; if (rx_b.size() != 4 || frame_err != 0)
      begin nerr++; $display("FAIL b2b_bytes: got %0d bytes err=%0d want 4/0", rx_b.size(), frame_err); end
    else begin
      for (int i = 0; i < 4; i++) begin
        nchecks++; if (rx_b[i] !== exp_b[i] || rx_t[i] != n0 + 1 + i * 10 * C)
          begin nerr++; $display("FAIL b2b_byte%0d: got %h@%0d want %h@%0d", i, rx_b[i], rx_t[i], exp_b[i], n0 + 1 + i * 10 * C); end
      end
    end
    nchecks++; if (busy !== 1'b0 || empty !== 1'b1)
      begin nerr++; $display("FAIL b2b_idle: busy=%b empty=%b want 0/1", busy, empty); end
  endtask

  task automatic test_overflow();
    logic [15:0] w[6];
    int n[6];
    do_reset(); clear_mon();
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) begin
      push(w[i], n[i]);
      if (i == 3) begin
        nchecks++; if (full !== 1'b0) begin nerr++; $display("FAIL ovf_full_early: got %b want 0", full); end
      end
      if (i == 4) begin
        nchecks++; if (full !== 1'b1 || overflow !== 1'b0)
          begin nerr++; $display("FAIL ovf_fifth: full=%b overflow=%b want 1/0", full, overflow); end
      end
    end
    nchecks++; if (overflow !== 1'b1 || full !== 1'b1)
      begin nerr++; $display("FAIL ovf_sixth: overflow=%b full=%b want 1/1", overflow, full); end
    repeat (5 * WORD_CYC + 30) @(posedge clk); #1;
    nchecks++; if (rx_b.size() != 10 || frame_err != 0)
      begin nerr++; $display("FAIL ovf_bytes: got %0d bytes err=%0d want 10/0", rx_b.size(), frame_err); end
    else begin
      nchecks++; if (rx_t[0] != n[0] + 1)
        begin nerr++; $display("FAIL ovf_first_pop: got %0d want %0d", rx_t[0], n[0] + 1); end
      for (int i = 0; i < 5; i++) begin
        nchecks++; if ({rx_b[2*i], rx_b[2*i+1]} !== w[i])
          begin nerr++; $display("FAIL ovf_word%0d: got %h%h want %h", i, rx_b[2*i], rx_b[2*i+1], w[i]); end
      end
    end
    nchecks++; if (overflow !== 1'b1 || empty !== 1'b1 || busy !== 1'b0)
      begin nerr++; $display("FAIL ovf_end: overflow=%b empty=%b busy=%b want 1/1/0", overflow, empty, busy); end
  endtask

  task automatic test_push_pop();
    logic [15:0] a, b;
    int na, nb;
    a = 16'($urandom); b = 16'($urandom);
    do_reset(); clear_mon();
    push(a, na);
    push(b, nb);
    nchecks++; if (empty !== 1'b0 || full !== 1'b0 || busy !== 1'b1)
      begin nerr++; $display("FAIL pp_count: empty=%b full=%b busy=%b want 0/0/1", empty, full, busy); end
    @(posedge clk); #1;
    nchecks++; if (empty !== 1'b0)
      begin nerr++; $display("FAIL pp_hold: empty=%b want 0", empty); end
    repeat (2 * WORD_CYC + 20) @(posedge clk); #1;
    nchecks++; if (rx_b.size() != 4 || frame_err != 0)
      begin nerr++; $display("FAIL pp_bytes: got %0d bytes err=%0d want 4/0", rx_b.size(), frame_err); end
    else begin
      nchecks++; if ({rx_b[0], rx_b[1]} !== a || {rx_b[2], rx_b[3]} !== b)
        begin nerr++; $display("FAIL pp_order: got %h%h %h%h want %h %h", rx_b[0], rx_b[1], rx_b[2], rx_b[3], a, b); end
      nchecks++; if (rx_t[2] != rx_t[0] + WORD_CYC)
        begin nerr++; $display("FAIL pp_contig: got %0d want %0d", rx_t[2], rx_t[0] + WORD_CYC); end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    do_reset(); clear_mon();
    for (int i = 0; i < 3; i++) push(16'($urandom), n);
    repeat (12) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    nchecks++; if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0)
      begin nerr++; $display("FAIL midrst_async: tx=%b empty=%b busy=%b full=%b want 1/1/0/0", tx, empty, busy, full); end
    repeat (2) @(negedge clk);
    clear_mon();
    clr = 1'b1;
    repeat (3 * WORD_CYC) @(posedge clk); #1;
    nchecks++; if (mon_starts != 0 || rx_b.size() != 0 || busy !== 1'b0 || tx !== 1'b1)
      begin nerr++; $display("FAIL midrst_silent: starts=%0d bytes=%0d busy=%b tx=%b want 0/0/0/1", mon_starts, rx_b.size(), busy, tx); end
  endtask

  // Random write schedule checked against a word-level timing model: a word
  // starts at max(write+1, end of previous word); it is dropped if DEPTH
  // earlier words are still waiting in the FIFO at its write edge.
  task automatic test_random(input int round);
    int wt[$]; logic [15:0] wd[$];
    int at[$]; int st[$]; logic [15:0] ad[$];
    int off, base, idx, cnt, last_end, s, t, wait_n;
    logic ovf_exp;
    do_reset(); clear_mon();
    off = 0;
    for (int k = 0; k < 12; k++) begin
      off += $urandom_range(1, 45);
      wt.push_back(off); wd.push_back(16'($urandom));
    end
    idx = 0; base = 0;
    for (int c = 0; c <= off; c++) begin
      @(negedge clk);
      if (c == 0) base = cyc + 1;
      if (idx < 12 && wt[idx] == c) begin wr_en = 1'b1; wr_data = wd[idx]; idx++; end
      else wr_en = 1'b0;
    end
    @(negedge clk); wr_en = 1'b0;
    ovf_exp = 1'b0; last_end = 0;
    for (int k = 0; k < 12; k++) begin
      t = base + wt[k]; cnt = 0;
      for (int j = 0; j < at.size(); j++) if (at[j] < t && st[j] >= t) cnt++;
      if (cnt >= DEPTH) ovf_exp = 1'b1;
      else begin
        s = (t + 1 > last_end) ? t + 1 : last_end;
        at.push_back(t); st.push_back(s); ad.push_back(wd[k]);
        last_end = s + WORD_CYC;
      end
    end
    wait_n = last_end + 20 - cyc;
    if (wait_n > 0) repeat (wait_n) @(posedge clk);
    #1;
    nchecks++; if (overflow !== ovf_exp)
      begin nerr++; $display("FAIL rnd%0d_overflow: got %b want %b", round, overflow, ovf_exp); end
    nchecks++; if (rx_b.size() != 2 * ad.size() || frame_err != 0)
      begin nerr++; $display("FAIL rnd%0d_bytes: got %0d err=%0d want %0d/0", round, rx_b.size(), frame_err, 2 * ad.size()); end
    else begin
      for (int i = 0; i < ad.size(); i++) begin
        nchecks++; if ({rx_b[2*i], rx_b[2*i+1]} !== ad[i] || rx_t[2*i] != st[i] || rx_t[2*i+1] != st[i] + 10 * C)
          begin nerr++; $display("FAIL rnd%0d_word%0d: got %h%h@%0d want %h@%0d", round, i, rx_b[2*i], rx_b[2*i+1], rx_t[2*i], ad[i], st[i]); end
      end
    end
    nchecks++; if (busy !== 1'b0 || empty !== 1'b1)
      begin nerr++; $display("FAIL rnd%0d_idle: busy=%b empty=%b want 0/1", round, busy, empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_reset_midframe();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
